// File: rtl/cpu_mem_pkg.sv
// Shared types and encodings for the CPU memory controller:
// FSM state enum, status-pin encoding, external target select and
// small decode helpers used by the top-level FSM.
package cpu_mem_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_DONE = 3'd3,
    S_READ = 3'd4
  } state_t;

  // Encoding of the 2-bit status mode-request input
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_LOAD = 2'b01;
  localparam logic [1:0] ST_RUN  = 2'b10;
  localparam logic [1:0] ST_READ = 2'b11;

  // External port target select
  localparam logic SEL_IM = 1'b0;
  localparam logic SEL_DM = 1'b1;

  // Map a status request onto the state it asks for
  function automatic state_t status_to_state(input logic [1:0] s);
    case (s)
      ST_LOAD: return S_LOAD;
      ST_RUN:  return S_RUN;
      ST_READ: return S_READ;
      default: return S_IDLE;
    endcase
  endfunction

  // States in which the external port owns the memories
  function automatic logic is_ext_state(input state_t s);
    return (s == S_LOAD) || (s == S_READ);
  endfunction

endpackage

// File: rtl/cpu_mem_ctrl_if.sv
// Bus bundle for cpu_mem_ctrl: external load/readout handshake and the
// core fetch/data port. "master" drives requests, "slave" is the controller.
//
// Handshake: a request transfers on the rising edge where ext_valid and
// ext_ready are both high. The requester holds ext_sel/ext_we/ext_addr/
// ext_wdata stable while ext_valid is high; ext_ready never depends on
// ext_valid. A read transfer returns ext_rdata qualified by a one-cycle
// ext_rvalid pulse in the following cycle; there is no backpressure on
// the response.
interface cpu_mem_ctrl_if #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int INSTR_W = 16
);

  logic               ext_valid;
  logic               ext_ready;
  logic               ext_sel;
  logic               ext_we;
  logic [ADDR_W-1:0]  ext_addr;
  logic [INSTR_W-1:0] ext_wdata;
  logic [INSTR_W-1:0] ext_rdata;
  logic               ext_rvalid;

  logic [ADDR_W-1:0]  core_pc;
  logic [INSTR_W-1:0] core_im_rdata;
  logic [ADDR_W-1:0]  core_dar;
  logic               core_dm_we;
  logic [DATA_W-1:0]  core_dm_wdata;
  logic [DATA_W-1:0]  core_dm_rdata;

  modport master (
    output ext_valid, ext_sel, ext_we, ext_addr, ext_wdata,
    output core_pc, core_dar, core_dm_we, core_dm_wdata,
    input  ext_ready, ext_rdata, ext_rvalid, core_im_rdata, core_dm_rdata
  );

  modport slave (
    input  ext_valid, ext_sel, ext_we, ext_addr, ext_wdata,
    input  core_pc, core_dar, core_dm_we, core_dm_wdata,
    output ext_ready, ext_rdata, ext_rvalid, core_im_rdata, core_dm_rdata
  );

endinterface

// File: rtl/sync_ram.sv
// Single-port RAM: synchronous write, registered read with enable.
// A read and write to the same address in one cycle returns the old word.
// The array is not reset; only the read register is.
module sync_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Commit writes on the clock edge
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Registered read, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (en) rdata <= mem[addr];
  end

endmodule

// File: rtl/cpu_mem_ctrl.sv
// CPU memory subsystem: instruction + data memory shared between the core
// and an external load/readout port, with a status-driven mode FSM.
// Optional macro CPU_MEM_BOUNDS_EN: out-of-range accesses are suppressed,
// read as zero and raise a sticky addr_err; without it addresses wrap.
module cpu_mem_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int INSTR_W  = 16,
  parameter int ADDR_W   = 16,
  parameter int DM_DEPTH = 256,
  parameter int IM_DEPTH = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     status,
  input  logic           end_process,
  output logic           core_run,
  output logic           done,
  output logic           addr_err,
  output state_t         state_dbg,
  cpu_mem_ctrl_if.slave  bus
);

  localparam int IM_AW = (IM_DEPTH > 1) ? $clog2(IM_DEPTH) : 1;
  localparam int DM_AW = (DM_DEPTH > 1) ? $clog2(DM_DEPTH) : 1;

  state_t state_q, state_d;
  logic   ext_ready_q, core_run_q, done_q;

  // Next-state logic: status selects the mode, RUN can finish into DONE
  always_comb begin
    state_d = status_to_state(status);
    case (state_q)
      S_RUN: begin
        if (end_process)          state_d = S_DONE;
        else if (status == ST_RUN) state_d = S_RUN;
      end
      S_DONE: begin
        if (status == ST_RUN) state_d = S_DONE;
      end
      default: ;
    endcase
  end

  // State register plus ownership outputs; these rise one edge after entry
  // and fall on the exiting edge so no port is granted outside its state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ext_ready_q <= 1'b0;
      core_run_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ext_ready_q <= is_ext_state(state_q) && is_ext_state(state_d);
      core_run_q  <= (state_q == S_RUN) && (state_d == S_RUN);
      done_q      <= (state_d == S_DONE);
    end
  end

  assign state_dbg     = state_q;
  assign core_run      = core_run_q;
  assign done          = done_q;
  assign bus.ext_ready = ext_ready_q;

  // Port muxing: the core owns both memories in RUN, otherwise the external port
  logic              in_run, ext_acc;
  logic [ADDR_W-1:0] im_addr_full, dm_addr_full;
  logic              im_oob, dm_oob;
  logic              im_en, im_we, dm_en, dm_we;
  logic [DATA_W-1:0] dm_wdata;

  assign in_run       = (state_q == S_RUN);
  assign ext_acc      = bus.ext_valid & ext_ready_q;
  assign im_addr_full = in_run ? bus.core_pc  : bus.ext_addr;
  assign dm_addr_full = in_run ? bus.core_dar : bus.ext_addr;

`ifdef CPU_MEM_BOUNDS_EN
  logic addr_err_q;
  assign im_oob = ({1'b0, im_addr_full} >= (ADDR_W+1)'(IM_DEPTH));
  assign dm_oob = ({1'b0, dm_addr_full} >= (ADDR_W+1)'(DM_DEPTH));

  // Sticky flag for any enabled out-of-range access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_err_q <= 1'b0;
    else        addr_err_q <= addr_err_q | (im_en & im_oob) | (dm_en & dm_oob);
  end
  assign addr_err = addr_err_q;
`else
  logic unused_addr_bits;
  assign im_oob           = 1'b0;
  assign dm_oob           = 1'b0;
  assign unused_addr_bits = ^{im_addr_full, dm_addr_full};
  assign addr_err         = 1'b0;
`endif

  // Memory enables; external writes only commit in LOAD
  always_comb begin
    im_en    = 1'b0;
    im_we    = 1'b0;
    dm_en    = 1'b0;
    dm_we    = 1'b0;
    dm_wdata = bus.ext_wdata[DATA_W-1:0];
    if (in_run) begin
      im_en    = 1'b1;
      dm_en    = 1'b1;
      dm_we    = bus.core_dm_we & ~dm_oob;
      dm_wdata = bus.core_dm_wdata;
    end else if (ext_acc) begin
      if (bus.ext_sel == SEL_IM) begin
        im_en = 1'b1;
        im_we = bus.ext_we & (state_q == S_LOAD) & ~im_oob;
      end else begin
        dm_en = 1'b1;
        dm_we = bus.ext_we & (state_q == S_LOAD) & ~dm_oob;
      end
    end
  end

  logic [INSTR_W-1:0] im_rdata;
  logic [DATA_W-1:0]  dm_rdata;

  sync_ram #(.WIDTH(INSTR_W), .DEPTH(IM_DEPTH)) u_im (
    .clk(clk), .rst_n(rst_n), .en(im_en), .we(im_we),
    .addr(im_addr_full[IM_AW-1:0]), .wdata(bus.ext_wdata), .rdata(im_rdata)
  );

  sync_ram #(.WIDTH(DATA_W), .DEPTH(DM_DEPTH)) u_dm (
    .clk(clk), .rst_n(rst_n), .en(dm_en), .we(dm_we),
    .addr(dm_addr_full[DM_AW-1:0]), .wdata(dm_wdata), .rdata(dm_rdata)
  );

  // Read-return tracking and hold registers so outputs keep their last value
  logic               ext_rd_q, ext_rd_sel_q, ext_rd_oob_q;
  logic               core_rd_q, core_im_oob_q, core_dm_oob_q;
  logic [INSTR_W-1:0] ext_hold_q, core_im_hold_q, ext_rdata_c, core_im_c;
  logic [DATA_W-1:0]  core_dm_hold_q, core_dm_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_rd_q       <= 1'b0;
      ext_rd_sel_q   <= 1'b0;
      ext_rd_oob_q   <= 1'b0;
      core_rd_q      <= 1'b0;
      core_im_oob_q  <= 1'b0;
      core_dm_oob_q  <= 1'b0;
      ext_hold_q     <= '0;
      core_im_hold_q <= '0;
      core_dm_hold_q <= '0;
    end else begin
      ext_rd_q       <= ext_acc & ~bus.ext_we;
      ext_rd_sel_q   <= bus.ext_sel;
      ext_rd_oob_q   <= (bus.ext_sel == SEL_DM) ? dm_oob : im_oob;
      core_rd_q      <= in_run;
      core_im_oob_q  <= im_oob;
      core_dm_oob_q  <= dm_oob;
      ext_hold_q     <= ext_rdata_c;
      core_im_hold_q <= core_im_c;
      core_dm_hold_q <= core_dm_c;
    end
  end

  // Select fresh RAM data in the cycle after a read, else the held value
  always_comb begin
    ext_rdata_c = ext_hold_q;
    core_im_c   = core_im_hold_q;
    core_dm_c   = core_dm_hold_q;
    if (ext_rd_q) begin
      if (ext_rd_oob_q)                ext_rdata_c = '0;
      else if (ext_rd_sel_q == SEL_DM) ext_rdata_c = INSTR_W'(dm_rdata);
      else                             ext_rdata_c = im_rdata;
    end
    if (core_rd_q) begin
      core_im_c = core_im_oob_q ? '0 : im_rdata;
      core_dm_c = core_dm_oob_q ? '0 : dm_rdata;
    end
  end

  assign bus.ext_rvalid    = ext_rd_q;
  assign bus.ext_rdata     = ext_rdata_c;
  assign bus.core_im_rdata = core_im_c;
  assign bus.core_dm_rdata = core_dm_c;

endmodule

// File: tb/tb_cpu_mem_ctrl.sv
// Self-checking bench for cpu_mem_ctrl: directed load/run/readout vectors,
// external read data checked by a queue-based monitor.
module tb_cpu_mem_ctrl;
  import cpu_mem_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [1:0]  status;
  logic        end_process;
  logic        core_run;
  logic        done;
  logic        addr_err;
  state_t      state_dbg;

  cpu_mem_ctrl_if bus ();

  cpu_mem_ctrl dut (
    .clk(clk), .rst_n(rst_n), .status(status), .end_process(end_process),
    .core_run(core_run), .done(done), .addr_err(addr_err),
    .state_dbg(state_dbg), .bus(bus)
  );

  int n_cmp = 0;
  int n_mis = 0;
  logic [15:0] exp_q[$];

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every ext_rvalid pulse pops one expected read word
  always @(negedge clk) begin
    if (rst_n && bus.ext_rvalid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("FAIL rvalid_unexpected: got rdata %0h expected no response", bus.ext_rdata);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("ext_rdata", 32'(bus.ext_rdata), 32'(e));
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_status(input logic [1:0] s);
    status = s;
    step();
    step();
  endtask

  task automatic ext_write(input logic sel, input logic [15:0] addr, input logic [15:0] data);
    bus.ext_sel   = sel;
    bus.ext_addr  = addr;
    bus.ext_wdata = data;
    bus.ext_we    = 1'b1;
    bus.ext_valid = 1'b1;
    step();
    bus.ext_valid = 1'b0;
    bus.ext_we    = 1'b0;
  endtask

  task automatic ext_read(input logic sel, input logic [15:0] addr, input logic [15:0] exp);
    bus.ext_sel   = sel;
    bus.ext_addr  = addr;
    bus.ext_we    = 1'b0;
    bus.ext_valid = 1'b1;
    exp_q.push_back(exp);
    step();
    bus.ext_valid = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ext_ready"},  32'(bus.ext_ready), 32'd0);
    chk({tag, "_ext_rvalid"}, 32'(bus.ext_rvalid), 32'd0);
    chk({tag, "_ext_rdata"},  32'(bus.ext_rdata), 32'd0);
    chk({tag, "_core_run"},   32'(core_run), 32'd0);
    chk({tag, "_done"},       32'(done), 32'd0);
    chk({tag, "_im_rdata"},   32'(bus.core_im_rdata), 32'd0);
    chk({tag, "_dm_rdata"},   32'(bus.core_dm_rdata), 32'd0);
    chk({tag, "_addr_err"},   32'(addr_err), 32'd0);
    chk({tag, "_state"},      32'(state_dbg), 32'(S_IDLE));
  endtask

  logic [15:0] exp_oob_dm, exp_oob_im;
  logic        exp_err;

  initial begin
`ifdef CPU_MEM_BOUNDS_EN
    exp_oob_dm = 16'h0000;
    exp_oob_im = 16'h0000;
    exp_err    = 1'b1;
`else
    exp_oob_dm = 16'h00E7;
    exp_oob_im = 16'hA55A;
    exp_err    = 1'b0;
`endif
    rst_n = 1'b0;
    status = ST_IDLE;
    end_process = 1'b0;
    bus.ext_valid = 1'b0;
    bus.ext_sel = SEL_IM;
    bus.ext_we = 1'b0;
    bus.ext_addr = '0;
    bus.ext_wdata = '0;
    bus.core_pc = '0;
    bus.core_dar = '0;
    bus.core_dm_we = 1'b0;
    bus.core_dm_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("rst");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // LOAD: fill memories
    set_status(ST_LOAD);
    chk("load_ready", 32'(bus.ext_ready), 32'd1);
    chk("load_state", 32'(state_dbg), 32'(S_LOAD));
    ext_write(SEL_IM, 16'd3, 16'hA55A);
    ext_read(SEL_IM, 16'd3, 16'hA55A);
    @(negedge clk);
    chk("rvalid_lat1", 32'(bus.ext_rvalid), 32'd1);
    step();
    @(negedge clk);
    chk("rvalid_pulse", 32'(bus.ext_rvalid), 32'd0);
    step();
    ext_write(SEL_DM, 16'd5, 16'h003C);
    ext_write(SEL_DM, 16'd7, 16'h0011);
    ext_write(SEL_DM, 16'd2, 16'h005A);
    ext_write(SEL_DM, 16'd0, 16'h00E7);
    ext_write(SEL_IM, 16'd4, 16'h1234);
    // back-to-back reads
    ext_read(SEL_DM, 16'd5, 16'h003C);
    ext_read(SEL_IM, 16'd4, 16'h1234);
    ext_read(SEL_DM, 16'd2, 16'h005A);

    // RUN: core owns memories
    bus.core_pc  = 16'd3;
    bus.core_dar = 16'd5;
    status = ST_RUN;
    step();
    chk("run_ready0", 32'(bus.ext_ready), 32'd0);
    chk("run_corerun_lag", 32'(core_run), 32'd0);
    step();
    chk("run_corerun", 32'(core_run), 32'd1);
    chk("run_dm5", 32'(bus.core_dm_rdata), 32'h3C);
    chk("run_im3", 32'(bus.core_im_rdata), 32'hA55A);
    bus.core_dar = 16'd2;
    step();
    chk("run_dm2", 32'(bus.core_dm_rdata), 32'h5A);
    bus.core_dar = 16'd7;
    bus.core_dm_we = 1'b1;
    bus.core_dm_wdata = 8'h91;
    step();
    chk("run_rw_old", 32'(bus.core_dm_rdata), 32'h11);
    bus.core_dm_we = 1'b0;
    step();
    chk("run_dm7_new", 32'(bus.core_dm_rdata), 32'h91);
    bus.ext_sel = SEL_DM;
    bus.ext_addr = 16'd7;
    bus.ext_we = 1'b1;
    bus.ext_valid = 1'b1;
    step();
    chk("run_ready_held0", 32'(bus.ext_ready), 32'd0);
    bus.ext_valid = 1'b0;
    bus.ext_we = 1'b0;
    end_process = 1'b1;
    step();
    chk("done_set", 32'(done), 32'd1);
    chk("done_corerun0", 32'(core_run), 32'd0);
    chk("done_state", 32'(state_dbg), 32'(S_DONE));
    end_process = 1'b0;
    bus.core_dar = 16'd2;
    bus.core_dm_we = 1'b1;
    bus.core_dm_wdata = 8'hFF;
    step();
    bus.core_dm_we = 1'b0;
    chk("done_held", 32'(done), 32'd1);
    chk("done_dm_hold", 32'(bus.core_dm_rdata), 32'h91);

    // READ: readout only
    status = ST_READ;
    step();
    chk("read_done0", 32'(done), 32'd0);
    step();
    chk("read_ready", 32'(bus.ext_ready), 32'd1);
    ext_read(SEL_DM, 16'd7, 16'h0091);
    ext_write(SEL_DM, 16'd2, 16'h0077);
    ext_read(SEL_DM, 16'd2, 16'h005A);
    ext_read(SEL_DM, 16'h0100, exp_oob_dm);
    @(negedge clk);
    chk("addr_err_dm", 32'(addr_err), 32'(exp_err));
    step();
    step();
    chk("addr_err_sticky", 32'(addr_err), 32'(exp_err));
    ext_read(SEL_IM, 16'h0103, exp_oob_im);

    // Reset in the middle of RUN
    set_status(ST_RUN);
    chk("run2_corerun", 32'(core_run), 32'd1);
    rst_n = 1'b0;
    status = ST_IDLE;
    #2;
    chk_reset("midrun");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset aborting a pending read response
    set_status(ST_LOAD);
    bus.ext_sel = SEL_IM;
    bus.ext_addr = 16'd3;
    bus.ext_we = 1'b0;
    bus.ext_valid = 1'b1;
    step();
    bus.ext_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_rvalid", 32'(bus.ext_rvalid), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_no_rvalid", 32'(bus.ext_rvalid), 32'd0);

    // Contents survive reset
    status = ST_IDLE;
    step();
    set_status(ST_LOAD);
    ext_read(SEL_IM, 16'd3, 16'hA55A);
    ext_read(SEL_IM, 16'd4, 16'h1234);

    // Drain with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL drain: got %0d outstanding reads expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
